// File: rtl/adt7420_poll_scheduler.sv
// adt7420_poll_scheduler
// Sequences the ADT7420 threshold writes after reset or reload, then polls
// TEMP_VALUE periodically through a shared I2C master. It publishes the
// temperature and alarm flags, retries failed cfg/poll transfers, and (when
// built with ADT_HOST_PORT_EN) arbitrates a host register-access port.
// Without ADT_HOST_PORT_EN the host inputs are ignored and the host outputs
// are tied to zero.
//
// state | meaning
// CFG   | load the next threshold write job (HIGH, LOW, CRIT)
// IDLE  | wait for a free master, then grant retry > reload > host > poll
// ISSUE | pulse m_newd for the latched job and arm the watchdog
// WAIT  | wait for m_done or watchdog expiry; publish results
// FIN   | decide on advance, retry or fault
module adt7420_poll_scheduler #(
  parameter int          POLL_PERIOD_CYC = 4000000,
  parameter int          TIMEOUT_CYC     = 20000,
  parameter int          MAX_RETRY       = 3,
  parameter logic [15:0] HIGH_DEF        = 16'h2000,
  parameter logic [15:0] LOW_DEF         = 16'h0500,
  parameter logic [15:0] CRIT_DEF        = 16'h2800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        cfg_reload,
  input  logic        host_req,
  input  logic        host_op,
  input  logic [7:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_done,
  output logic        host_err,
  output logic [15:0] host_rdata,
  output logic        m_newd,
  output logic [7:0]  m_addr,
  output logic        m_op,
  output logic [15:0] m_din,
  input  logic [15:0] m_dout,
  input  logic        m_busy,
  input  logic        m_done,
  input  logic        m_ack_err,
  output logic [15:0] temp_val,
  output logic        temp_valid,
  output logic        over_high,
  output logic        under_low,
  output logic        over_crit,
  output logic        fault
);

  typedef enum logic [2:0] {CFG, IDLE, ISSUE, WAIT, FIN} state_t;
  typedef enum logic [1:0] {SRC_CFG, SRC_HOST, SRC_POLL} src_t;

  localparam logic [31:0] POLL_LAST = 32'(POLL_PERIOD_CYC - 1);
  localparam logic [31:0] WD_LOAD   = 32'(TIMEOUT_CYC - 1);
  localparam logic [3:0]  MAX_R     = 4'(MAX_RETRY);

  state_t      state;
  src_t        src;
  logic [1:0]  cfg_idx;
  logic [31:0] poll_cnt;
  logic [31:0] wdog;
  logic [3:0]  retry;
  logic        poll_pend;
  logic        reload_pend;
  logic        retry_pend;
  logic        failed;

  logic [7:0]  cfg_addr;
  logic [15:0] cfg_din;
  logic        grant_retry;
  logic        grant_reload;
  logic        grant_poll;

`ifdef ADT_HOST_PORT_EN
  logic        grant_host;
`else
  logic        unused_host;
  assign unused_host = ^{host_req, host_op, host_addr, host_wdata};
  assign host_done   = 1'b0;
  assign host_err    = 1'b0;
  assign host_rdata  = 16'h0000;
`endif

  // threshold write table indexed by cfg_idx
  always_comb begin
    cfg_addr = 8'h08;
    cfg_din  = CRIT_DEF;
    case (cfg_idx)
      2'd0: begin cfg_addr = 8'h04; cfg_din = HIGH_DEF; end
      2'd1: begin cfg_addr = 8'h06; cfg_din = LOW_DEF;  end
      default: ;
    endcase
  end

  // IDLE arbitration: a pending retry finishes first, then reload, host, poll
  always_comb begin
    grant_retry  = 1'b0;
    grant_reload = 1'b0;
    grant_poll   = 1'b0;
`ifdef ADT_HOST_PORT_EN
    grant_host   = 1'b0;
`endif
    if (state == IDLE && !m_busy) begin
      if (retry_pend)           grant_retry  = 1'b1;
      else if (reload_pend)     grant_reload = 1'b1;
`ifdef ADT_HOST_PORT_EN
      else if (host_req)        grant_host   = 1'b1;
`endif
      else if (poll_pend && en) grant_poll   = 1'b1;
    end
  end

  // sequencer, poll timer, watchdog and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CFG;
      src         <= SRC_CFG;
      cfg_idx     <= 2'd0;
      poll_cnt    <= 32'd0;
      wdog        <= 32'd0;
      retry       <= 4'd0;
      poll_pend   <= 1'b0;
      reload_pend <= 1'b0;
      retry_pend  <= 1'b0;
      failed      <= 1'b0;
      m_newd      <= 1'b0;
      m_addr      <= 8'h00;
      m_op        <= 1'b0;
      m_din       <= 16'h0000;
      temp_val    <= 16'h0000;
      temp_valid  <= 1'b0;
      over_high   <= 1'b0;
      under_low   <= 1'b0;
      over_crit   <= 1'b0;
      fault       <= 1'b0;
`ifdef ADT_HOST_PORT_EN
      host_done   <= 1'b0;
      host_err    <= 1'b0;
      host_rdata  <= 16'h0000;
`endif
    end else begin
      m_newd     <= 1'b0;
      temp_valid <= 1'b0;
`ifdef ADT_HOST_PORT_EN
      host_done  <= 1'b0;
`endif

      // a tick that lands while a poll is already pending is dropped
      if (!en) begin
        poll_cnt  <= 32'd0;
        poll_pend <= 1'b0;
      end else begin
        poll_cnt <= (poll_cnt == POLL_LAST) ? 32'd0 : poll_cnt + 32'd1;
        if (grant_poll)                poll_pend <= 1'b0;
        else if (poll_cnt == POLL_LAST) poll_pend <= 1'b1;
      end

      if (grant_reload) reload_pend <= 1'b0;
      if (cfg_reload)   reload_pend <= 1'b1;

      unique case (state)
        CFG: begin
          if (!m_busy) begin
            m_addr <= cfg_addr;
            m_op   <= 1'b0;
            m_din  <= cfg_din;
            src    <= SRC_CFG;
            retry  <= 4'd0;
            state  <= ISSUE;
          end
        end
        IDLE: begin
          if (grant_retry) begin
            retry_pend <= 1'b0;
            state      <= ISSUE;
          end else if (grant_reload) begin
            fault   <= 1'b0;
            cfg_idx <= 2'd0;
            retry   <= 4'd0;
            state   <= CFG;
          end
`ifdef ADT_HOST_PORT_EN
          else if (grant_host) begin
            m_addr <= host_addr;
            m_op   <= host_op;
            m_din  <= host_wdata;
            src    <= SRC_HOST;
            retry  <= 4'd0;
            state  <= ISSUE;
          end
`endif
          else if (grant_poll) begin
            m_addr <= 8'h00;
            m_op   <= 1'b1;
            m_din  <= 16'h0000;
            src    <= SRC_POLL;
            retry  <= 4'd0;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          m_newd <= 1'b1;
          wdog   <= WD_LOAD;
          state  <= WAIT;
        end
        WAIT: begin
          // results are published here so they appear one cycle after m_done
          if (m_done) begin
            failed <= m_ack_err;
            state  <= FIN;
            if (!m_ack_err && src == SRC_POLL) begin
              temp_val   <= m_dout;
              temp_valid <= 1'b1;
              over_high  <= $signed(m_dout) >= $signed(HIGH_DEF);
              under_low  <= $signed(m_dout) <= $signed(LOW_DEF);
              over_crit  <= $signed(m_dout) >= $signed(CRIT_DEF);
            end
`ifdef ADT_HOST_PORT_EN
            if (src == SRC_HOST) begin
              host_done <= 1'b1;
              host_err  <= m_ack_err;
              if (!m_ack_err) host_rdata <= m_dout;
            end
`endif
          end else if (wdog == 32'd0) begin
            failed <= 1'b1;
            state  <= FIN;
`ifdef ADT_HOST_PORT_EN
            if (src == SRC_HOST) begin
              host_done <= 1'b1;
              host_err  <= 1'b1;
            end
`endif
          end else begin
            wdog <= wdog - 32'd1;
          end
        end
        FIN: begin
          if (!failed) begin
            retry <= 4'd0;
            if (src == SRC_CFG) begin
              cfg_idx <= cfg_idx + 2'd1;
              state   <= (cfg_idx == 2'd2) ? IDLE : CFG;
            end else begin
              state <= IDLE;
            end
          end else if (src == SRC_HOST) begin
            state <= IDLE;
          end else if (retry < MAX_R) begin
            // retries go back through IDLE so a timed-out master can drain
            retry      <= retry + 4'd1;
            retry_pend <= 1'b1;
            state      <= IDLE;
          end else begin
            fault <= 1'b1;
            retry <= 4'd0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
